// File: rtl/audio_framer.sv
// audio_framer: gathers the incoming sample stream into overlapping frames of
// FRAME_LEN samples and presents each complete frame, oldest sample first,
// together with a single-cycle frame_ready strobe. A new frame is produced
// every HOP accepted samples once the first full frame has been collected.
module audio_framer #(
  parameter int DATA_WIDTH = 12,
  parameter int FRAME_LEN  = 256,
  parameter int HOP        = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  restart,
  output logic [DATA_WIDTH-1:0] frame_out [0:FRAME_LEN-1],
  output logic                  frame_ready,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int PTR_W  = $clog2(FRAME_LEN);
  localparam int FILL_W = PTR_W + 1;
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FRAME_LEN - 1);
  localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [FILL_W-1:0]     fill_cnt, fill_cnt_nxt;
  logic [HOP_W-1:0]      hop_cnt, hop_cnt_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [DATA_WIDTH-1:0] sample_buf [0:FRAME_LEN-1];
  logic                  emit_now;

  // State and counter registers; restart is folded into the next-state logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FILL;
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      hop_cnt  <= hop_cnt_nxt;
    end
  end

  // Next state: fill once, then emit every HOP accepts; the EMIT cycle's accept starts the next hop.
  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    hop_cnt_nxt  = hop_cnt;
    emit_now     = 1'b0;
    if (restart) begin
      state_nxt    = FILL;
      fill_cnt_nxt = '0;
      hop_cnt_nxt  = '0;
    end else begin
      case (state)
        FILL: begin
          if (sample_valid) begin
            fill_cnt_nxt = fill_cnt + FILL_W'(1);
            if (fill_cnt == FILL_LAST) begin
              state_nxt = EMIT;
            end
          end
        end
        RUN, EMIT: begin
          if (state == EMIT) begin
            emit_now  = 1'b1;
            state_nxt = RUN;
          end
          if (sample_valid) begin
            if (hop_cnt == HOP_LAST) begin
              hop_cnt_nxt = '0;
              state_nxt   = EMIT;
            end else begin
              hop_cnt_nxt = hop_cnt + HOP_W'(1);
            end
          end
        end
        default: begin
          state_nxt = FILL;
        end
      endcase
    end
  end

  // Sample storage, frame snapshot (rotated so the oldest sample lands at index 0) and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        sample_buf[k] <= '0;
        frame_out[k]  <= '0;
      end
      wr_ptr      <= '0;
      frame_ready <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b1;
    end else begin
      frame_ready <= 1'b0;
      if (restart) begin
        wr_ptr      <= '0;
        frame_count <= '0;
        busy        <= 1'b1;
      end else begin
        if (sample_valid) begin
          sample_buf[wr_ptr] <= sample_in;
          wr_ptr             <= wr_ptr + PTR_W'(1);
        end
        if (emit_now) begin
          for (int k = 0; k < FRAME_LEN; k++) begin
            frame_out[k] <= sample_buf[wr_ptr + PTR_W'(k)];
          end
          frame_ready <= 1'b1;
          frame_count <= frame_count + 16'd1;
          busy        <= 1'b0;
        end
      end
    end
  end

endmodule
